// File: rtl/icram_bist_engine_pkg.sv
// Shared definitions for the icache data RAM BIST engine.
// Holds the state and element encodings, the per-element March C- attributes and the data backgrounds.
package icram_bist_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_MARCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    typedef enum logic [2:0] {
        EL_E0 = 3'd0,
        EL_E1 = 3'd1,
        EL_E2 = 3'd2,
        EL_E3 = 3'd3,
        EL_E4 = 3'd4,
        EL_E5 = 3'd5
    } march_elem_e;

    typedef struct packed {
        logic desc;    // walk addresses high to low
        logic rd_inv;  // read expects ~B instead of B
        logic wr_inv;  // write stores ~B instead of B
        logic has_rd;
        logic has_wr;
    } elem_attr_t;

    localparam logic [31:0] BG0 = 32'h0000_0000;
    localparam logic [31:0] BG1 = 32'h5555_5555;

    function automatic elem_attr_t elem_attr(input march_elem_e e);
        elem_attr_t a;
        a = '0;
        case (e)
            EL_E0:   a = '{desc: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
            EL_E1:   a = '{desc: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            EL_E2:   a = '{desc: 1'b0, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            EL_E3:   a = '{desc: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            EL_E4:   a = '{desc: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            EL_E5:   a = '{desc: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/icram_bist_cmp.sv
// Read-data checker: carries expected word and address across the RAM's one-cycle read latency,
// compares against the returned line and keeps a sticky error flag plus the first failing address.
module icram_bist_cmp #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              clr_i,
    input  logic              rd_vld_i,
    input  logic [63:0]       rd_exp_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [63:0]       dout_i,
    output logic              err_l_o,
    output logic [ADDR_W-1:0] fail_addr_o
);

    logic              s1_vld_q;
    logic [63:0]       s1_exp_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              err_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic              miscmp;

    assign miscmp = s1_vld_q && (dout_i != s1_exp_q);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1_vld_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_addr_q   <= '0;
            err_q       <= 1'b0;
            fail_addr_q <= '0;
        end else if (clr_i) begin
            s1_vld_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_addr_q   <= '0;
            err_q       <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            s1_vld_q  <= rd_vld_i;
            s1_exp_q  <= rd_exp_i;
            s1_addr_q <= rd_addr_i;
            if (miscmp) begin
                err_q <= 1'b1;
                // Only the earliest miscompare in time is reported.
                if (!err_q) fail_addr_q <= s1_addr_q;
            end
        end
    end

    assign err_l_o     = ~err_q;
    assign fail_addr_o = fail_addr_q;

endmodule

// File: rtl/icram_bist_engine.sv
// March C- BIST sequencer for the icache data RAM, run under two data backgrounds.
// Drives the RAM's BIST port and hands read expectations to icram_bist_cmp.
module icram_bist_engine
    import icram_bist_engine_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              bist_start,
    output logic              bist_active,
    output logic              bist_enable,
    output logic [ADDR_W-1:0] bist_icu_addr,
    output logic [31:0]       bist_icu_din,
    output logic [1:0]        bist_icu_ram_we,
    input  logic [63:0]       icram_dout,
    output logic              bist_done,
    output logic              icache_test_err_l,
    output logic [ADDR_W-1:0] bist_fail_addr,
    output bist_state_e       bist_state
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    bist_state_e       state_q, state_d;
    march_elem_e       elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;  // 0 = read slot, 1 = write slot
    logic              bg_q, bg_d;
    logic              drain_q, drain_d;

    elem_attr_t  attr;
    logic [31:0] bg_word;
    logic        in_march, rd_cycle, wr_cycle, last_op, at_end, clr;

    assign attr     = elem_attr(elem_q);
    assign bg_word  = bg_q ? BG1 : BG0;
    assign in_march = (state_q == ST_MARCH);
    assign rd_cycle = in_march && attr.has_rd && !phase_q;
    assign wr_cycle = in_march && attr.has_wr && (phase_q || !attr.has_rd);
    assign last_op  = !(attr.has_rd && attr.has_wr) || phase_q;
    assign at_end   = attr.desc ? (addr_q == '0) : (addr_q == ADDR_MAX);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            elem_q  <= EL_E0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            bg_q    <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            bg_q    <= bg_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        bg_d    = bg_q;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    state_d = ST_SETUP;
                    bg_d    = 1'b0;
                    clr     = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_MARCH;
                elem_d  = EL_E0;
                addr_d  = '0;
                phase_d = 1'b0;
            end
            ST_MARCH: begin
                if (!last_op) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!at_end) begin
                        addr_d = attr.desc ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    end else if (elem_q == EL_E5) begin
                        elem_d = EL_E0;
                        addr_d = '0;
                        if (bg_q) begin
                            state_d = ST_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            bg_d = 1'b1;
                        end
                    end else begin
                        // Each element starts from its own end of the array, not where the last one wrapped.
                        elem_d = march_elem_e'(elem_q + 3'd1);
                        addr_d = elem_attr(elem_d).desc ? ADDR_MAX : '0;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bist_active     = (state_q == ST_SETUP) || in_march || (state_q == ST_DRAIN);
    assign bist_enable     = bist_active;
    assign bist_done       = (state_q == ST_DONE);
    assign bist_icu_addr   = in_march ? addr_q : '0;
    assign bist_icu_din    = in_march ? (bg_word ^ {32{attr.wr_inv}}) : 32'h0;
    assign bist_icu_ram_we = wr_cycle ? 2'b11 : 2'b00;
    assign bist_state      = state_q;

    icram_bist_cmp #(.ADDR_W(ADDR_W)) u_cmp (
        .clk        (clk),
        .reset_l    (reset_l),
        .clr_i      (clr),
        .rd_vld_i   (rd_cycle),
        .rd_exp_i   ({2{bg_word ^ {32{attr.rd_inv}}}}),
        .rd_addr_i  (addr_q),
        .dout_i     (icram_dout),
        .err_l_o    (icache_test_err_l),
        .fail_addr_o(bist_fail_addr)
    );

endmodule

// File: tb/tb_icram_bist_engine.sv
// Bench for icram_bist_engine with ADDR_W = 3 against a behavioural RAM with injectable faults.
module tb_icram_bist_engine;
    import icram_bist_engine_pkg::*;

    localparam int AW = 3;
    localparam int N  = 1 << AW;
    localparam int RUN_CYC = 20 * N + 3;

    logic          clk = 1'b0;
    logic          reset_l = 1'b0;
    logic          bist_start = 1'b0;
    logic          bist_active, bist_enable, bist_done, icache_test_err_l;
    logic [AW-1:0] bist_icu_addr, bist_fail_addr;
    logic [31:0]   bist_icu_din;
    logic [1:0]    bist_icu_ram_we;
    logic [63:0]   icram_dout;
    bist_state_e   bist_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cyc;
        logic          err_l;
        logic [AW-1:0] fail;
        int            writes;
    } run_exp_t;
    run_exp_t exp_q[$];

    always #5 clk = ~clk;

    icram_bist_engine #(.ADDR_W(AW)) dut (
        .clk              (clk),
        .reset_l          (reset_l),
        .bist_start       (bist_start),
        .bist_active      (bist_active),
        .bist_enable      (bist_enable),
        .bist_icu_addr    (bist_icu_addr),
        .bist_icu_din     (bist_icu_din),
        .bist_icu_ram_we  (bist_icu_ram_we),
        .icram_dout       (icram_dout),
        .bist_done        (bist_done),
        .icache_test_err_l(icache_test_err_l),
        .bist_fail_addr   (bist_fail_addr),
        .bist_state       (bist_state)
    );

    // RAM model: 0 ideal, 1 bit17 of line 5 stuck-at-1, 2 bit17 of lines 2 and 6 stuck-at-1,
    // 3 writing line 3 inverts line 4.
    int            fault_mode = 0;
    logic [63:0]   mem [N];
    logic [AW-1:0] ram_addr_q = '0;

    initial for (int i = 0; i < N; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (bist_enable && bist_active) begin
            if (bist_icu_ram_we == 2'b11) begin
                mem[bist_icu_addr] <= {bist_icu_din, bist_icu_din};
                if (fault_mode == 3 && bist_icu_addr == 3'd3) mem[4] <= ~mem[4];
            end
            ram_addr_q <= bist_icu_addr;
        end
    end

    always_comb begin
        icram_dout = mem[ram_addr_q];
        if (fault_mode == 1 && ram_addr_q == 3'd5) icram_dout[17] = 1'b1;
        if (fault_mode == 2 && (ram_addr_q == 3'd2 || ram_addr_q == 3'd6)) icram_dout[17] = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle count: 0 on the edge that samples an accepted start.
    int   cyc = 0;
    logic arm = 1'b0;
    logic running = 1'b0;
    int   wr_cnt = 0;

    always @(posedge clk) begin
        if (arm && bist_start) begin
            cyc     = 0;
            arm     = 1'b0;
            running = 1'b1;
            wr_cnt  = 0;
        end else begin
            cyc = cyc + 1;
        end
    end

    // Monitor: pops one expected result each time the engine reports done.
    always @(negedge clk) begin
        if (running) begin
            if (bist_icu_ram_we == 2'b11) wr_cnt++;
            if (bist_done) begin
                running = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    run_exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("err_l_at_done", 64'(icache_test_err_l), 64'(e.err_l));
                    check("fail_addr_at_done", 64'(bist_fail_addr), 64'(e.fail));
                    check("write_count", 64'(wr_cnt), 64'(e.writes));
                    check("active_low_at_done", 64'(bist_active), 64'd0);
                end
            end else if (cyc > RUN_CYC + 50) begin
                running = 1'b0;
                check("done_timeout", 1'b1, 1'b0);
            end
        end
    end

    task automatic start_run(input logic push, input logic err_l, input logic [AW-1:0] fail);
        run_exp_t e;
        if (push) begin
            e.cyc    = RUN_CYC;
            e.err_l  = err_l;
            e.fail   = fail;
            e.writes = 2 * 5 * N;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bist_start = 1'b1;
        arm        = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        int g = 0;
        while (cyc != c && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != c) check("wait_cyc_timeout", 64'(cyc), 64'(c));
    endtask

    task automatic wait_idle();
        int g = 0;
        while (running && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (running) begin
            check("wait_idle_timeout", 1'b1, 1'b0);
            running = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_active"}, 64'(bist_active), 64'd0);
        check({tag, "_enable"}, 64'(bist_enable), 64'd0);
        check({tag, "_addr"}, 64'(bist_icu_addr), 64'd0);
        check({tag, "_din"}, 64'(bist_icu_din), 64'd0);
        check({tag, "_we"}, 64'(bist_icu_ram_we), 64'd0);
        check({tag, "_done"}, 64'(bist_done), 64'd0);
        check({tag, "_err_l"}, 64'(icache_test_err_l), 64'd1);
        check({tag, "_fail"}, 64'(bist_fail_addr), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_state", 64'(bist_state), 64'(ST_IDLE));

        // Clean run with sequencing spot checks.
        fault_mode = 0;
        start_run(1'b1, 1'b1, 3'd0);
        check("setup_active", 64'(bist_active), 64'd1);
        check("setup_we", 64'(bist_icu_ram_we), 64'd0);
        wait_cyc(1);
        check("e0_first_we", 64'(bist_icu_ram_we), 64'h3);
        check("e0_first_din", 64'(bist_icu_din), 64'h0);
        wait_cyc(9);
        check("e1_read_we", 64'(bist_icu_ram_we), 64'h0);
        wait_cyc(10);
        check("e1_write_din", 64'(bist_icu_din), 64'hffff_ffff);
        wait_cyc(41);
        check("e3_start_addr", 64'(bist_icu_addr), 64'd7);
        wait_cyc(81);
        check("b1_e0_din", 64'(bist_icu_din), 64'h5555_5555);
        wait_idle();

        // Stuck-at bit 17 on line 5: first E1 read of line 5 is issued in cycle 19.
        fault_mode = 1;
        start_run(1'b1, 1'b0, 3'd5);
        wait_cyc(20);
        check("stuck_err_before", 64'(icache_test_err_l), 64'd1);
        wait_cyc(21);
        check("stuck_err_after", 64'(icache_test_err_l), 64'd0);
        check("stuck_fail_addr", 64'(bist_fail_addr), 64'd5);
        wait_idle();

        // Restart from DONE clears the sticky error and fail address.
        fault_mode = 0;
        start_run(1'b1, 1'b1, 3'd0);
        check("restart_err_cleared", 64'(icache_test_err_l), 64'd1);
        check("restart_fail_cleared", 64'(bist_fail_addr), 64'd0);
        wait_idle();

        fault_mode = 2;
        start_run(1'b1, 1'b0, 3'd2);
        wait_idle();

        fault_mode = 3;
        start_run(1'b1, 1'b0, 3'd4);
        wait_idle();

        // Start pulse during MARCH must not restart or stretch the run.
        fault_mode = 0;
        start_run(1'b1, 1'b1, 3'd0);
        wait_cyc(50);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        check("start_ignored_state", 64'(bist_state), 64'(ST_MARCH));
        wait_idle();

        // Mid-run reset after a fault has been latched.
        fault_mode = 1;
        start_run(1'b0, 1'b1, 3'd0);
        wait_cyc(40);
        check("pre_reset_err_l", 64'(icache_test_err_l), 64'd0);
        #2 reset_l = 1'b0;
        #1 running = 1'b0;
        check_reset_outputs("midrun");
        check("midrun_state", 64'(bist_state), 64'(ST_IDLE));
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        fault_mode = 0;
        start_run(1'b1, 1'b1, 3'd0);
        wait_idle();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
